// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// WORD_SIZE sets the default datapath width when the build does not provide it.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package mdu_pkg;

  localparam int MDU_WORD  = `WORD_SIZE;
  localparam int MDU_ITERS = MDU_WORD;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // Magnitude of an operand; unsigned ops pass through untouched.
  // The most negative value maps onto its own bit pattern, which is the
  // correct unsigned magnitude.
  function automatic logic [MDU_WORD-1:0] abs_val(input logic signed [MDU_WORD-1:0] v,
                                                   input logic is_signed);
    logic signed [MDU_WORD-1:0] neg;
    neg = -v;
    return (is_signed && v[MDU_WORD-1]) ? $unsigned(neg) : $unsigned(v);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 iteration engine: shift-add multiply and restoring divide on
// unsigned magnitudes. Holds the double-width working register and counter.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_WORD,
  parameter int CNT_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    is_div,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic [2*DATA_WIDTH-1:0] acc,
  output logic                    last
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0]   acc_q;
  logic [2*W-1:0]   acc_d;
  logic [W-1:0]     opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W:0]       sum;
  logic [W:0]       rem_sh;
  logic [W:0]       diff;

  // One iteration: {carry,hi} accumulates the multiplicand while the
  // multiplier shifts out of the low half; divide shifts the dividend into
  // the remainder and keeps the subtraction only when it does not borrow.
  always_comb begin
    sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = acc_q[2*W-1:W-1];
    diff   = rem_sh - {1'b0, opnd_q};
    acc_d  = {sum, acc_q[W-1:1]};
    if (is_div) begin
      if (diff[W]) acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
      else         acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    end
  end

  // Working register and second operand; contents only matter after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      acc_q  <= {{W{1'b0}}, op_a};
      opnd_q <= op_b;
    end else if (step) begin
      acc_q  <= acc_d;
    end
  end

  // Iteration counter, cleared on reset and on every new operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt_q <= '0;
    else if (load) cnt_q <= '0;
    else if (step) cnt_q <= cnt_q + 1'b1;
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Optional MDU_ZERO_SKIP_EN: multiplies with a zero operand bypass the
// iteration phase and complete in two edges with identical results.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_WORD,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  mult_div_unit_if.slave        bus
);

  localparam int W = DATA_WIDTH;

  mdu_state_t     state;
  logic [W-1:0]   hi_q, lo_q, a_hold_q;
  logic           done_q, dz_q, div_q, neg_q, rem_neg_q, skip_q, div0_q;
  logic           op_mul, op_div, op_signed, a_zero, b_zero, mul_skip, load;
  logic [W-1:0]   mag_a, mag_b;
  logic [2*W-1:0] acc;
  logic           last;

  assign op_mul    = (bus.op == MULT) || (bus.op == MULTU);
  assign op_div    = (bus.op == DIV)  || (bus.op == DIVU);
  assign op_signed = (bus.op == MULT) || (bus.op == DIV);
  assign a_zero    = (bus.src_a == '0);
  assign b_zero    = (bus.src_b == '0);
  assign mag_a     = abs_val(bus.src_a, op_signed);
  assign mag_b     = abs_val(bus.src_b, op_signed);
  assign load      = (state == IDLE) && bus.start && (op_mul || op_div);

`ifdef MDU_ZERO_SKIP_EN
  assign mul_skip = a_zero || b_zero;
`else
  assign mul_skip = 1'b0;
`endif

  mdu_iter_core #(
    .DATA_WIDTH (W),
    .CNT_W      (CNT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (state == CALC),
    .is_div (div_q),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .acc    (acc),
    .last   (last)
  );

  // Control FSM plus HI/LO ownership: accept in IDLE, iterate in CALC,
  // sign-correct and commit in FIX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_hold_q  <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      skip_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MTHI: hi_q <= bus.src_a;
              MTLO: lo_q <= bus.src_a;
              MULT, MULTU: begin
                div_q  <= 1'b0;
                neg_q  <= op_signed && (bus.src_a[W-1] ^ bus.src_b[W-1]);
                skip_q <= mul_skip;
                div0_q <= 1'b0;
                state  <= mul_skip ? FIX : CALC;
              end
              DIV, DIVU: begin
                div_q     <= 1'b1;
                neg_q     <= op_signed && (bus.src_a[W-1] ^ bus.src_b[W-1]);
                rem_neg_q <= op_signed && bus.src_a[W-1];
                skip_q    <= 1'b0;
                div0_q    <= b_zero;
                dz_q      <= b_zero;
                a_hold_q  <= bus.src_a;
                state     <= b_zero ? FIX : CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (last) state <= FIX;
        end
        FIX: begin
          if (div0_q) begin
            hi_q <= a_hold_q;
            lo_q <= '1;
          end else if (skip_q) begin
            hi_q <= '0;
            lo_q <= '0;
          end else if (div_q) begin
            lo_q <= neg_q ? -acc[W-1:0] : acc[W-1:0];
            hi_q <= rem_neg_q ? -acc[2*W-1:W] : acc[2*W-1:W];
          end else begin
            {hi_q, lo_q} <= neg_q ? -acc : acc;
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
